eco_sweep_ctrl: RTL and testbench
=================================

# eco_sweep_ctrl

Exhaustive-sweep controller for ECO validation of the 5-bit-in / 3-bit-out gate-level test netlists. It drives all 1024 {B, A} operand combinations into an original netlist and an ECO-patched netlist that are instantiated externally in parallel. After a programmable settle delay it compares their Y outputs, counts mismatches and captures the first failing vector. It sits between the bench or top-level test harness and the two netlist instances.

## Interface
Parameters:
- SETTLE_CYC, 2, cycles operands are held before comparison; legal range 1..15
- Y_MASK, 3'b111, per-bit compare enable for Y; 0 bits are ignored

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle pulse; begins a sweep from IDLE or DONE
- abort  input  1  level; terminates a running sweep
- op_a  output  5  operand A to both netlists, registered
- op_b  output  5  operand B to both netlists, registered
- y_ref  input  3  Y from the original netlist
- y_eco  input  3  Y from the ECO-patched netlist
- busy  output  1  high in SETTLE and CHECK
- done  output  1  high in DONE
- pass  output  1  done && err_cnt == 0
- err_cnt  output  11  count of mismatching vectors, saturating at 1024
- first_idx  output  10  {op_b, op_a} of the first mismatch
- first_ref  output  3  y_ref captured at the first mismatch
- first_eco  output  3  y_eco captured at the first mismatch
- mism  output  1  sticky; set on the first mismatch

## Operation
- Vector index idx[9:0]: op_a = idx[4:0], op_b = idx[9:5]. Sweep order is 0 to 1023.
- FSM states are IDLE, SETTLE, CHECK and DONE.
- IDLE / DONE, on start with abort low:
  - idx, settle counter, err_cnt, mism and first_* are cleared to 0.
  - Next state is SETTLE.
- SETTLE:
  - The settle counter runs 0 to SETTLE_CYC-1.
  - At terminal count the FSM goes to CHECK.
- CHECK:
  - Compare ((y_ref ^ y_eco) & Y_MASK) != 0.
  - On mismatch, err_cnt increments.
  - If mism was 0 on that mismatch: capture first_idx = idx, first_ref and first_eco, and set mism.
  - If idx == 1023, next state is DONE. Otherwise idx increments, the settle counter clears, and the FSM returns to SETTLE.
- DONE:
  - done is held high and results are frozen until the next start.
- abort high in SETTLE or CHECK:
  - Next state is IDLE.
  - Results are retained. done stays 0. The compare in an aborted CHECK cycle is discarded.
- start while busy is ignored.
- start and abort in the same cycle in IDLE/DONE: abort wins and there is no start.
- err_cnt cannot exceed 1024. It still saturates at 11'h400 by construction.

## Timing
- Reset values: state IDLE; op_a, op_b, busy, done, pass, err_cnt, first_idx, first_ref, first_eco and mism all 0.
- op_a/op_b change on the edge that enters SETTLE for a new idx. y_ref/y_eco are sampled on the edge that leaves CHECK.
- Per-vector cost is SETTLE_CYC+1 cycles.
- done rises 1024·(SETTLE_CYC+1) cycles after the edge that samples start.
- busy falls on the same edge that done rises.
- Reset asserted mid-sweep returns all outputs to reset values immediately (asynchronously). No sweep resumes after reset deasserts.

## Configuration
- ECO_SWEEP_STOP_EN defined: a mismatch in CHECK sends the FSM to DONE on that edge regardless of idx. err_cnt is then at most 1, and first_idx identifies the stopping vector.
- ECO_SWEEP_STOP_EN undefined: the full 1024-vector sweep always runs, counting every mismatch.

## Test plan
- Equivalent netlists: y_eco = y_ref, SETTLE_CYC=2, start → done after 3072 cycles, pass=1, err_cnt=0, mism=0.
- Single fault: y_eco = y_ref ^ 3'b100 only when op_a=3 and op_b=0 → err_cnt=1, first_idx=10'd3, first_eco=first_ref^3'b100, pass=0.
- Masking: same fault with Y_MASK=3'b011 → err_cnt=0, pass=1. Fault on bit 0 at idx 5 with Y_MASK=3'b011 → err_cnt=1, first_idx=5.
- Abort and restart:
  - abort pulsed 100 cycles after start → busy=0 next cycle, done stays 0.
  - A following start clears err_cnt and completes the full sweep.
- Reset mid-sweep: rst pulsed at cycle 500 → op_a=op_b=0, busy=0, err_cnt=0 in the same cycle. The FSM stays in IDLE until start.
- Early stop: faults at idx 3 and idx 7, SETTLE_CYC=2.
  - ECO_SWEEP_STOP_EN defined → done 12 cycles after start, err_cnt=1.
  - ECO_SWEEP_STOP_EN undefined → done after 3072 cycles, err_cnt=2, first_idx=3.

Source files
------------

// File: rtl/eco_sweep_ctrl.sv
// Exhaustive 1024-vector sweep controller comparing an original and an ECO-patched 5-in/3-out netlist.
// Optional macro ECO_SWEEP_STOP_EN: stop the sweep at the first mismatch.
module eco_sweep_ctrl #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter logic [2:0]  Y_MASK     = 3'b111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  op_a,
    output logic [4:0]  op_b,
    input  logic [2:0]  y_ref,
    input  logic [2:0]  y_eco,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [10:0] err_cnt,
    output logic [9:0]  first_idx,
    output logic [2:0]  first_ref,
    output logic [2:0]  first_eco,
    output logic        mism
);
    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    localparam logic [3:0] CNT_TC = 4'(SETTLE_CYC - 1);

    state_t      state;
    logic [9:0]  idx;
    logic [3:0]  cnt;
    logic        diff;
    logic        stop;
    logic [10:0] err_inc;

    assign op_a    = idx[4:0];
    assign op_b    = idx[9:5];
    assign diff    = |((y_ref ^ y_eco) & Y_MASK);
    assign err_inc = (err_cnt == 11'h400) ? err_cnt : err_cnt + 11'd1;
`ifdef ECO_SWEEP_STOP_EN
    assign stop    = (idx == 10'd1023) || diff;
`else
    assign stop    = (idx == 10'd1023);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            first_idx <= '0;
            first_ref <= '0;
            first_eco <= '0;
            mism      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start && !abort) begin
                        state     <= SETTLE;
                        idx       <= '0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_cnt   <= '0;
                        first_idx <= '0;
                        first_ref <= '0;
                        first_eco <= '0;
                        mism      <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_TC) begin
                        state <= CHECK;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                CHECK: begin
                    if (abort) begin
                        // aborted compare is discarded; prior results stay visible
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (diff) begin
                            err_cnt <= err_inc;
                            if (!mism) begin
                                mism      <= 1'b1;
                                first_idx <= idx;
                                first_ref <= y_ref;
                                first_eco <= y_eco;
                            end
                        end
                        if (stop) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= !diff && (err_cnt == 11'd0);
                        end else begin
                            state <= SETTLE;
                            idx   <= idx + 10'd1;
                            cnt   <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_eco_sweep_ctrl.sv
// Directed bench: two controllers (full mask and Y_MASK=3'b011) swept in lockstep against injected faults.
module tb_eco_sweep_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    int   mode = 0;
    int   vecs = 0;
    int   errs = 0;
    int   cyc1, cyc2;

    logic [4:0]  a1, b1, a2, b2;
    logic [2:0]  yr1, ye1, yr2, ye2, fr1, fe1, fr2, fe2;
    logic        busy1, done1, pass1, mism1, busy2, done2, pass2, mism2;
    logic [10:0] err1, err2;
    logic [9:0]  fi1, fi2;

`ifdef ECO_SWEEP_STOP_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    always #5 clk = ~clk;

    // fault injected on the ECO side per scenario
    function automatic logic [2:0] flt(input int m, input logic [9:0] i);
        case (m)
            1: return (i == 10'd3) ? 3'b100 : 3'b000;
            2: return (i == 10'd5) ? 3'b001 : 3'b000;
            3: return (i == 10'd3 || i == 10'd7) ? 3'b001 : 3'b000;
            default: return 3'b000;
        endcase
    endfunction

    assign yr1 = a1[2:0] + b1[2:0];
    assign ye1 = yr1 ^ flt(mode, {b1, a1});
    assign yr2 = a2[2:0] + b2[2:0];
    assign ye2 = yr2 ^ flt(mode, {b2, a2});

    eco_sweep_ctrl #(.SETTLE_CYC(2), .Y_MASK(3'b111)) u1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .op_a(a1), .op_b(b1), .y_ref(yr1), .y_eco(ye1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .first_idx(fi1), .first_ref(fr1), .first_eco(fe1), .mism(mism1));

    eco_sweep_ctrl #(.SETTLE_CYC(2), .Y_MASK(3'b011)) u2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .op_a(a2), .op_b(b2), .y_ref(yr2), .y_eco(ye2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
        .first_idx(fi2), .first_ref(fr2), .first_eco(fe2), .mism(mism2));

    task automatic chk(input string tag, input int obs, input int exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // ev: 0 none, 1 extra start while busy, 2 abort, 3 async reset; fires ev_at cycles after start is sampled
    task automatic sweep(input int ev, input int ev_at);
        int n = 0;
        cyc1 = -1;
        cyc2 = -1;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (n < 4000) begin
            @(posedge clk);
            n++;
            #1;
            start = 1'b0;
            if (done1 && cyc1 < 0) cyc1 = n;
            if (done2 && cyc2 < 0) cyc2 = n;
            if (cyc1 >= 0 && cyc2 >= 0) break;
            if (n == ev_at) begin
                if (ev == 1) start = 1'b1;
                if (ev == 2) begin
                    abort = 1'b1;
                    @(posedge clk);
                    #1 abort = 1'b0;
                    return;
                end
                if (ev == 3) begin
                    #2 rst = 1'b1;
                    #1;
                    return;
                end
            end
        end
    endtask

    initial begin
        #3;
        chk("rst_op", {b1, a1}, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_err", err1, 0);
        chk("rst_mism", mism1, 0);
        #20 rst = 1'b0;

        // equivalent netlists, stray start mid-sweep must be ignored
        mode = 0;
        sweep(1, 50);
        chk("eq_cyc", cyc1, 3072);
        chk("eq_pass", pass1, 1);
        chk("eq_err", err1, 0);
        chk("eq_mism", mism1, 0);
        chk("eq_busy", busy1, 0);
        chk("eq_m_pass", pass2, 1);

        // bit-2 fault at idx 3; masked out on u2
        mode = 1;
        sweep(0, 0);
        chk("f1_cyc", cyc1, STOP ? 12 : 3072);
        chk("f1_err", err1, 1);
        chk("f1_idx", fi1, 3);
        chk("f1_ref", fr1, 3);
        chk("f1_eco", fe1, 7);
        chk("f1_pass", pass1, 0);
        chk("f1_mism", mism1, 1);
        chk("f1_m_err", err2, 0);
        chk("f1_m_pass", pass2, 1);
        chk("f1_m_cyc", cyc2, 3072);

        // bit-0 fault at idx 5 is seen through both masks
        mode = 2;
        sweep(0, 0);
        chk("f2_cyc", cyc1, STOP ? 18 : 3072);
        chk("f2_err", err1, 1);
        chk("f2_idx", fi1, 5);
        chk("f2_eco", fe1, 4);
        chk("f2_m_err", err2, 1);
        chk("f2_m_idx", fi2, 5);

        // two faults: early stop vs full count
        mode = 3;
        sweep(0, 0);
        chk("f3_cyc", cyc1, STOP ? 12 : 3072);
        chk("f3_err", err1, STOP ? 1 : 2);
        chk("f3_idx", fi1, 3);
        chk("f3_pass", pass1, 0);

        // start with abort in DONE: abort wins, results frozen
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk("sa_done", done1, 1);
        chk("sa_busy", busy1, 0);
        chk("sa_err", err1, STOP ? 1 : 2);

        // abort at cycle 100 (idx 33 in SETTLE), then full restart
        mode = 0;
        sweep(2, 100);
        chk("ab_busy", busy1, 0);
        chk("ab_done", done1, 0);
        chk("ab_op", {b1, a1}, 33);
        chk("ab_err", err1, 0);
        repeat (5) @(posedge clk);
        #1 chk("ab_idle", busy1, 0);
        sweep(0, 0);
        chk("rs_cyc", cyc1, 3072);
        chk("rs_pass", pass1, 1);

        // asynchronous reset mid-sweep
        sweep(3, 500);
        chk("mr_op", {b1, a1}, 0);
        chk("mr_busy", busy1, 0);
        chk("mr_err", err1, 0);
        chk("mr_done", done1, 0);
        @(negedge clk) rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("mr_idle_busy", busy1, 0);
        chk("mr_idle_op", {b1, a1}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
